// File: rtl/slot_stream_collector_pkg.sv
// slot_pkg: slot constants, FSM state type and index-wrap helper shared by sequencer and collector
package slot_pkg;
  localparam int IDX_W = 7;
  localparam int NUM_SLOTS = 106;
  localparam int SLOT_LEN = 53;
  localparam int DATA_W = 16;
  localparam int SUM_W = DATA_W + $clog2(SLOT_LEN + 1);
  localparam int CNT_W = 7;
  typedef enum logic {HUNT, RUN} state_e;
  typedef logic [IDX_W-1:0] idx_t;
  function automatic idx_t next_idx(idx_t idx);
    return (idx == idx_t'(NUM_SLOTS - 1)) ? '0 : idx + idx_t'(1);
  endfunction
endpackage

// File: rtl/slot_stream_collector_if.sv
// slot_stream_collector_if: stream in (iIdx/iValid/iData/iClrErr), per-slot result out (oValid/oSlot/oSum/oCount/oFrameDone/oSeqErr/oLenErr/oErrSticky)
interface slot_stream_collector_if;
  import slot_pkg::*;
  logic [IDX_W-1:0] iIdx;
  logic iValid;
  logic [DATA_W-1:0] iData;
  logic iClrErr;
  logic oValid;
  logic [IDX_W-1:0] oSlot;
  logic [SUM_W-1:0] oSum;
  logic [CNT_W-1:0] oCount;
  logic oFrameDone;
  logic oSeqErr;
  logic oLenErr;
  logic oErrSticky;
  modport master (
    output iIdx, iValid, iData, iClrErr,
    input oValid, oSlot, oSum, oCount, oFrameDone, oSeqErr, oLenErr, oErrSticky
  );
  modport slave (
    input iIdx, iValid, iData, iClrErr,
    output oValid, oSlot, oSum, oCount, oFrameDone, oSeqErr, oLenErr, oErrSticky
  );
endinterface

// File: rtl/slot_stream_collector_seq_checker.sv
// slot_seq_checker: idx_q_i/idx_i/cnt_i -> seq_ok_o (legal successor index) and len_ok_o (slot length exact)
module slot_seq_checker
  import slot_pkg::*;
(
  input  idx_t             idx_q_i,
  input  idx_t             idx_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             seq_ok_o,
  output logic             len_ok_o
);
  assign seq_ok_o = (idx_q_i < idx_t'(NUM_SLOTS)) && (idx_i == next_idx(idx_q_i));
  assign len_ok_o = cnt_i == CNT_W'(SLOT_LEN);
endmodule

// File: rtl/slot_stream_collector.sv
// slot_stream_collector: iClk/iRst_n plus slave bus; sums samples per slot index and reports each completed slot with sequence/length checks
module slot_stream_collector
  import slot_pkg::*;
(
  input logic iClk,
  input logic iRst_n,
  slot_stream_collector_if.slave bus
);
  state_e state_q, state_d;
  logic armed_q, armed_d;
  idx_t idx_q, idx_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  idx_t slot_q, slot_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic fd_q, fd_d;
  logic seq_q, seq_d;
  logic len_q, len_d;
  logic sticky_q, sticky_d;
  logic seq_ok, len_ok, change;
  logic [SUM_W-1:0] sample;
  slot_seq_checker u_chk (
    .idx_q_i (idx_q),
    .idx_i   (bus.iIdx),
    .cnt_i   (cnt_q),
    .seq_ok_o(seq_ok),
    .len_ok_o(len_ok)
  );
  assign change = bus.iIdx != idx_q;
  assign sample = bus.iValid ? SUM_W'(bus.iData) : '0;
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    idx_d = bus.iIdx;
    acc_d = acc_q;
    cnt_d = cnt_q;
    valid_d = 1'b0;
    slot_d = slot_q;
    sum_d = sum_q;
    count_d = count_q;
    fd_d = 1'b0;
    seq_d = 1'b0;
    len_d = 1'b0;
    if (state_q == HUNT) begin
      if (armed_q && change) begin
        state_d = RUN;
        acc_d = sample;
        cnt_d = CNT_W'(1);
      end
    end else if (change) begin
      valid_d = 1'b1;
      slot_d = idx_q;
      sum_d = acc_q;
      count_d = cnt_q;
      fd_d = idx_q == idx_t'(NUM_SLOTS - 1);
      seq_d = !seq_ok;
      len_d = !len_ok;
      acc_d = sample;
      cnt_d = CNT_W'(1);
    end else begin
      acc_d = acc_q + sample;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
    sticky_d = seq_d | len_d | (sticky_q & ~bus.iClrErr);
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= HUNT;
      armed_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      slot_q <= '0;
      sum_q <= '0;
      count_q <= '0;
      fd_q <= 1'b0;
      seq_q <= 1'b0;
      len_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      slot_q <= slot_d;
      sum_q <= sum_d;
      count_q <= count_d;
      fd_q <= fd_d;
      seq_q <= seq_d;
      len_q <= len_d;
      sticky_q <= sticky_d;
    end
  end
  assign bus.oValid = valid_q;
  assign bus.oSlot = slot_q;
  assign bus.oSum = sum_q;
  assign bus.oCount = count_q;
  assign bus.oFrameDone = fd_q;
  assign bus.oSeqErr = seq_q;
  assign bus.oLenErr = len_q;
  assign bus.oErrSticky = sticky_q;
endmodule

// File: doc/slot_stream_collector.md
Name: slot_stream_collector

Overview:
- Receive-side partner of the slot-index sequencer, which emits a 7-bit slot index 0..105 that advances once every 53 clocks and wraps after 105.
- Watches that index together with a qualified data stream and sums the samples that arrive during each slot.
- At each slot boundary it emits one result per slot and checks that index order and slot length match the sequencer contract.
- Sits between the sequencer/feature datapath and the downstream per-slot consumer, such as SVM partial-sum logic.

Parameters:
- IDX_W, 7: slot index width.
- NUM_SLOTS, 106: number of slots per frame; the index wraps from NUM_SLOTS-1 to 0.
- SLOT_LEN, 53: expected number of clocks per slot.
- DATA_W, 16: unsigned sample width.
- SUM_W, DATA_W+6: accumulator width. This is a localparam derived as DATA_W+$clog2(SLOT_LEN+1).

Ports:
- iClk, input, 1: clock. All logic is on the rising edge.
- iRst_n, input, 1: asynchronous active-low reset.
- iIdx, input, IDX_W: slot index from the sequencer.
- iValid, input, 1: iData is valid this cycle.
- iData, input, DATA_W: sample.
- iClrErr, input, 1: synchronous clear of the sticky error flag.
- oValid, output, 1: one-cycle pulse; oSlot, oSum and oCount are valid.
- oSlot, output, IDX_W: index of the slot just completed.
- oSum, output, SUM_W: sum of the valid samples in that slot.
- oCount, output, 7: clocks spent in that slot, saturating at 127.
- oFrameDone, output, 1: pulse together with oValid when oSlot == NUM_SLOTS-1.
- oSeqErr, output, 1: pulse together with oValid on an index discontinuity.
- oLenErr, output, 1: pulse together with oValid when oCount != SLOT_LEN.
- oErrSticky, output, 1: set by any oSeqErr or oLenErr; held until iClrErr.

Behaviour:
- Reset (asynchronous, iRst_n=0):
  - state=HUNT; idx_q=0, acc=0, cnt=0.
  - All outputs are 0.
- Reset mid-slot discards the partial slot with no output. After release the block returns to HUNT.
- Internal registers: idx_q (previous iIdx), acc (SUM_W bits), cnt (7 bits, saturating at 127).
- HUNT state:
  - Each cycle, idx_q <= iIdx; no accumulation and no outputs.
  - The first cycle after reset release only loads idx_q; no comparison is made.
  - From the second cycle on, if iIdx != idx_q: go to RUN, acc <= (iValid ? iData : 0), cnt <= 1, idx_q <= iIdx.
  - The partial slot seen at startup is never reported.
- RUN state, when iIdx == idx_q: acc <= acc + (iValid ? iData : 0), wrapping modulo 2^SUM_W; cnt <= min(cnt+1, 127).
- RUN state, when iIdx != idx_q (boundary at edge t):
  - Registered outputs appear at t+1, so latency is 1 clock from the first cycle of the new index.
  - oValid=1, oSlot=idx_q, oSum=acc, oCount=cnt.
  - The sample present at the boundary cycle belongs to the new slot: acc <= (iValid ? iData : 0), cnt <= 1, idx_q <= iIdx.
  - oSeqErr=1 unless iIdx == idx_q+1 with idx_q < NUM_SLOTS-1, or iIdx == 0 with idx_q == NUM_SLOTS-1.
  - Any iIdx >= NUM_SLOTS is a sequence error. After a sequence error the block stays in RUN and resyncs to the new index.
  - oLenErr=1 if cnt != SLOT_LEN.
  - oFrameDone=1 if idx_q == NUM_SLOTS-1.
- Pulse outputs (oValid, oFrameDone, oSeqErr, oLenErr) are 0 on every non-boundary cycle. oSlot, oSum and oCount hold their last values.
- Sticky flag:
  - oErrSticky <= 1 on any error pulse.
  - iClrErr clears it to 0. If a clear and an error occur in the same cycle, set wins.
- A constant index, such as a stalled sequencer, causes no output. cnt saturates at 127; acc keeps wrapping. Both are reported at the next boundary with oLenErr.
- There is no back-pressure: the consumer must accept oValid whenever it pulses. The minimum spacing between pulses is 1 clock, which only occurs under error conditions.

Decomposition:
- Package slot_pkg holds:
  - Constants IDX_W, NUM_SLOTS, SLOT_LEN, DATA_W.
  - The state enum {HUNT, RUN}.
  - A function next_idx(idx) that wraps at NUM_SLOTS.
- This package is shared with the sequencer so both ends use the same slot constants.
- One natural sub-module is slot_seq_checker. It is combinational: it takes idx_q, iIdx and cnt and produces seq_ok and len_ok.

Test Plan:
1. Counter-accurate stream, index 0..105 each held 53 clocks, iValid=1, iData=1, started mid-slot 3:
   - No output for the partial slot 3.
   - Then one oValid per slot with oSum=53, oCount=53, no errors.
   - oFrameDone with oSlot=105, then a wrap to slot 0 with no oSeqErr.
2. Slot 7 with iValid=1 only on cycles 0, 10 and 52 (iData=100, 200, 300):
   - oSum=600, oSlot=7.
   - The boundary-cycle sample is counted in slot 8, not slot 7.
3. Index jump 20 -> 22: the pulse reports oSlot=20 with oSeqErr=1 and oErrSticky=1. The next slot 22 -> 23 is clean. iClrErr drops the sticky flag.
4. Slot held for 40 clocks: oCount=40, oLenErr=1. Slot held for 200 clocks: oCount=127, oLenErr=1.
5. iData=0xFFFF with iValid=1 for 53 clocks: oSum=3473355 (53 × 65535, no overflow in SUM_W=22 bits).
6. iRst_n asserted at cycle 30 of slot 50, asynchronously between edges:
   - All outputs are 0 immediately.
   - After release the block is in HUNT: no output for the partial slot, first report at the next full slot.
